// File: rtl/ioctl_overlay_video.sv
// Parametrised video timing generator with a 1-bpp bitmap overlay loaded
// through the ioctl download port and composited over a background colour.
module ioctl_overlay_video #(
    parameter int         H_ACTIVE    = 640,
    parameter int         H_FP        = 16,
    parameter int         H_SYNC      = 96,
    parameter int         H_BP        = 48,
    parameter int         V_ACTIVE    = 480,
    parameter int         V_FP        = 10,
    parameter int         V_SYNC      = 2,
    parameter int         V_BP        = 33,
    parameter bit         HS_POL      = 1'b0,
    parameter bit         VS_POL      = 1'b0,
    parameter int         CE_DIV      = 4,
    parameter int         OVL_W       = 128,
    parameter int         OVL_H       = 64,
    parameter logic [7:0] OVL_INDEX   = 8'd1,
    parameter bit         BLEND       = 1'b0,
    parameter int         WAIT_CYCLES = 0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    input  logic        ovl_en,
    input  logic [11:0] ovl_x,
    input  logic [11:0] ovl_y,
    input  logic [23:0] fg_rgb,
    input  logic [23:0] bg_rgb,
    output logic        ovl_ready,
    output logic        ce_pix,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_HB,
    output logic        VGA_VB,
    output logic        VGA_DE
);
    localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DEPTH = OVL_W * OVL_H / 8;
    localparam int HW    = $clog2(HT + 1);
    localparam int VW    = $clog2(VT + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int DW    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8:1];
    endfunction

    logic [DW-1:0] div_q;
    logic          ce_q;
    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;
    state_t        st_q;
    logic [CW-1:0] cnt_q;
    logic          ovl_ready_q;
    logic [7:0]    ram [DEPTH];
    logic          acc_c;

    // Pixel enable: one pulse each time the divider wraps
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            ce_q  <= (div_q == DW'(CE_DIV - 1));
            div_q <= (div_q == DW'(CE_DIV - 1)) ? '0 : div_q + 1'b1;
        end
    end

    // Raster position counters
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (ce_q) begin
            if (h_q == HW'(HT - 1)) begin
                h_q <= '0;
                v_q <= (v_q == VW'(VT - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

    // Stage 1 combinational: region flags, overlay window and byte address
    logic          act_c, hs_c, vs_c, win_c;
    logic [12:0]   hx, vy, ox, oy, dx;
    logic [AW-1:0] addr_c;
    always_comb begin
        hx     = 13'(h_q);
        vy     = 13'(v_q);
        ox     = {1'b0, ovl_x};
        oy     = {1'b0, ovl_y};
        dx     = hx - ox;
        act_c  = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        hs_c   = (h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
        vs_c   = (v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
        win_c  = ovl_en && ovl_ready_q && act_c &&
                 (hx >= ox) && (hx < ox + 13'(OVL_W)) &&
                 (vy >= oy) && (vy < oy + 13'(OVL_H));
        addr_c = AW'(vy - oy) * AW'(OVL_W / 8) + AW'(dx[12:3]);
    end

    // Stage 1 registers; address forced to 0 outside the window keeps reads in range
    logic          s1_win_q, s1_hs_q, s1_vs_q, s1_hb_q, s1_vb_q;
    logic [AW-1:0] s1_addr_q;
    logic [2:0]    s1_bit_q;
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            s1_win_q  <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_hb_q   <= 1'b1;
            s1_vb_q   <= 1'b1;
            s1_addr_q <= '0;
            s1_bit_q  <= '0;
        end else if (ce_q) begin
            s1_win_q  <= win_c;
            s1_hs_q   <= hs_c;
            s1_vs_q   <= vs_c;
            s1_hb_q   <= (h_q >= HW'(H_ACTIVE));
            s1_vb_q   <= (v_q >= VW'(V_ACTIVE));
            s1_addr_q <= win_c ? addr_c : '0;
            s1_bit_q  <= dx[2:0];
        end
    end

    // Stage 2 combinational: bitmap fetch, MSB-first bit select and colour mix
    logic [7:0]  rd_c;
    logic        hit_c;
    logic [23:0] mix_c;
    always_comb begin
        rd_c  = ram[s1_addr_q];
        hit_c = s1_win_q && rd_c[3'd7 - s1_bit_q];
        mix_c = bg_rgb;
        if (hit_c)
            mix_c = BLEND ? {avg8(fg_rgb[23:16], bg_rgb[23:16]),
                             avg8(fg_rgb[15:8],  bg_rgb[15:8]),
                             avg8(fg_rgb[7:0],   bg_rgb[7:0])} : fg_rgb;
    end

    // Stage 2 registers: all VGA outputs, blanking forces black
    logic [23:0] rgb_q;
    logic        hs_q, vs_q, hb_q, vb_q, de_q;
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rgb_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            hb_q  <= 1'b1;
            vb_q  <= 1'b1;
            de_q  <= 1'b0;
        end else if (ce_q) begin
            rgb_q <= (s1_hb_q || s1_vb_q) ? 24'h0 : mix_c;
            hs_q  <= s1_hs_q ? HS_POL : ~HS_POL;
            vs_q  <= s1_vs_q ? VS_POL : ~VS_POL;
            hb_q  <= s1_hb_q;
            vb_q  <= s1_vb_q;
            de_q  <= ~(s1_hb_q | s1_vb_q);
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign VGA_HS = hs_q;
    assign VGA_VS = vs_q;
    assign VGA_HB = hb_q;
    assign VGA_VB = vb_q;
    assign VGA_DE = de_q;
    assign ce_pix = ce_q;

    assign acc_c = (st_q == S_LOAD) && ioctl_wr && (ioctl_addr < 25'(DEPTH));

    // Download FSM: overlay hidden for the whole load, ready only if every byte arrived
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            st_q        <= S_IDLE;
            cnt_q       <= '0;
            ovl_ready_q <= 1'b0;
        end else begin
            case (st_q)
                S_IDLE: if (ioctl_download && (ioctl_index == OVL_INDEX)) begin
                    st_q        <= S_LOAD;
                    cnt_q       <= '0;
                    ovl_ready_q <= 1'b0;
                end
                S_LOAD: begin
                    if (acc_c && (cnt_q != CW'(DEPTH)))
                        cnt_q <= cnt_q + 1'b1;
                    if (!ioctl_download) begin
                        st_q        <= S_IDLE;
                        ovl_ready_q <= (cnt_q == CW'(DEPTH));
                    end
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

    assign ovl_ready = ovl_ready_q;

    // Bitmap RAM write port, contents survive reset
    always_ff @(posedge clk_sys) begin
        if (acc_c)
            ram[ioctl_addr[AW-1:0]] <= ioctl_dout;
    end

    generate
        if (WAIT_CYCLES > 0) begin : g_wait
            localparam int WW = $clog2(WAIT_CYCLES + 1);
            logic [WW-1:0] wcnt_q;
            // Stall window after each accepted write; a new write reloads it
            always_ff @(posedge clk_sys) begin
                if (!reset_n)
                    wcnt_q <= '0;
                else if (acc_c)
                    wcnt_q <= WW'(WAIT_CYCLES);
                else if (wcnt_q != '0)
                    wcnt_q <= wcnt_q - 1'b1;
            end
            assign ioctl_wait = (wcnt_q != '0);
        end else begin : g_nowait
            assign ioctl_wait = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_ioctl_overlay_video.sv
// Randomised/directed bench: two instances (opaque with wait states, blended
// without) share all inputs and are checked every cycle against a raster model.
module tb_ioctl_overlay_video;
    localparam int HT = 24, VT = 12, DEPTH = 4, FRAME = HT * VT * 2, NWAIT = 3;

    logic        clk_sys = 1'b0, reset_n = 1'b0;
    logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0, ioctl_index = '0;
    logic        ovl_en = 1'b0;
    logic [11:0] ovl_x = '0, ovl_y = '0;
    logic [23:0] fg_rgb = '0, bg_rgb = '0;

    logic       wait0, ready0, ce0, hs0, vs0, hb0, vb0, de0;
    logic [7:0] r0, g0, b0;
    logic       wait1, ready1, ce1, hs1, vs1, hb1, vb1, de1;
    logic [7:0] r1, g1, b1;

    ioctl_overlay_video #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CE_DIV(2), .OVL_W(8), .OVL_H(4),
        .OVL_INDEX(8'd1), .BLEND(1'b0), .WAIT_CYCLES(NWAIT)
    ) dut0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(wait0), .ovl_en(ovl_en),
        .ovl_x(ovl_x), .ovl_y(ovl_y), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
        .ovl_ready(ready0), .ce_pix(ce0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
        .VGA_HS(hs0), .VGA_VS(vs0), .VGA_HB(hb0), .VGA_VB(vb0), .VGA_DE(de0)
    );

    ioctl_overlay_video #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CE_DIV(2), .OVL_W(8), .OVL_H(4),
        .OVL_INDEX(8'd1), .BLEND(1'b1), .WAIT_CYCLES(0)
    ) dut1 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(wait1), .ovl_en(ovl_en),
        .ovl_x(ovl_x), .ovl_y(ovl_y), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
        .ovl_ready(ready1), .ce_pix(ce1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
        .VGA_HS(hs1), .VGA_VS(vs1), .VGA_HB(hb1), .VGA_VB(vb1), .VGA_DE(de1)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #5ms;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    // Reference state
    int         n_vec = 0, n_err = 0;
    int         ncyc = 0, npix = 0, wl = 0;
    bit         ce_exp = 1'b0, acc_now = 1'b0, in_load = 1'b0, ref_ready = 1'b0;
    int         ref_cnt = 0;
    logic [7:0] ref_ram [DEPTH];
    logic [24:0] dl_a [8];
    logic [7:0]  dl_d [8];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b)) / 2;
        return 8'(s);
    endfunction

    function automatic bit pixel_on(input int h, input int v);
        int dx, dy;
        logic [7:0] byt;
        if (!ovl_en || !ref_ready || h >= 16 || v >= 8) return 1'b0;
        dx = h - int'(ovl_x);
        dy = v - int'(ovl_y);
        if (dx < 0 || dx >= 8 || dy < 0 || dy >= 4) return 1'b0;
        byt = ref_ram[dy + dx / 8];
        return byt[7 - dx % 8];
    endfunction

    // Expected outputs for the raster position two pixels behind the counters
    task automatic check_video();
        int q, h, v;
        bit hb, vb, hs, vs, hit;
        logic [4:0]  es;
        logic [23:0] e0, e1;
        q = npix - 2;
        if (q < 0) begin
            es = 5'b11110; e0 = '0; e1 = '0;
        end else begin
            h  = q % HT;
            v  = (q / HT) % VT;
            hb = (h >= 16);
            vb = (v >= 8);
            hs = !(h >= 18 && h < 20);
            vs = !(v == 9);
            hit = pixel_on(h, v);
            if (hb || vb) begin
                e0 = '0; e1 = '0;
            end else if (hit) begin
                e0 = fg_rgb;
                e1 = {avg(fg_rgb[23:16], bg_rgb[23:16]), avg(fg_rgb[15:8], bg_rgb[15:8]),
                      avg(fg_rgb[7:0], bg_rgb[7:0])};
            end else begin
                e0 = bg_rgb; e1 = bg_rgb;
            end
            es = {hs, vs, hb, vb, !(hb || vb)};
        end
        chk("sync0", 48'({hs0, vs0, hb0, vb0, de0}), 48'(es));
        chk("sync1", 48'({hs1, vs1, hb1, vb1, de1}), 48'(es));
        chk("rgb0", 48'({r0, g0, b0}), 48'(e0));
        chk("rgb1", 48'({r1, g1, b1}), 48'(e1));
    endtask

    task automatic step(input bit chk_vid);
        @(posedge clk_sys);
        if (!reset_n) begin
            ncyc = 0; npix = 0; ce_exp = 1'b0; wl = 0;
        end else begin
            if (ce_exp) npix++;
            ncyc++;
            ce_exp = (ncyc % 2 == 0);
            if (acc_now) wl = NWAIT;
            else if (wl > 0) wl--;
        end
        #1;
        chk("ce0", 48'(ce0), 48'(ce_exp));
        chk("ce1", 48'(ce1), 48'(ce_exp));
        chk("wait0", 48'(wait0), 48'(wl > 0));
        chk("wait1", 48'(wait1), 48'(0));
        if (chk_vid) check_video();
    endtask

    task automatic settle();
        for (int i = 0; i < 8; i++) step(1'b0);
    endtask

    task automatic frame();
        int de_c, hs_c, vs_c;
        bit steady;
        de_c = 0; hs_c = 0; vs_c = 0;
        steady = (ncyc >= 8);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1);
            de_c += int'(de0);
            hs_c += int'(!hs0);
            vs_c += int'(!vs0);
        end
        if (steady) begin
            chk("de_cycles", 48'(de_c), 48'(256));
            chk("hs_cycles", 48'(hs_c), 48'(48));
            chk("vs_cycles", 48'(vs_c), 48'(48));
        end
    endtask

    // Loader: honours ioctl_wait except on byte 1 when viol is set
    task automatic download(input logic [7:0] idx, input int nb, input bit viol);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        step(1'b0);
        if (idx == 8'd1) begin
            in_load = 1'b1; ref_cnt = 0; ref_ready = 1'b0;
        end
        for (int b = 0; b < nb; b++) begin
            if (!(viol && b == 1)) begin
                for (int k = 0; k < 20 && wait0; k++) step(1'b0);
                chk("wait_clear", 48'(wait0), 48'(0));
            end
            ioctl_addr = dl_a[b];
            ioctl_dout = dl_d[b];
            ioctl_wr   = 1'b1;
            acc_now    = in_load && (dl_a[b] < 25'(DEPTH));
            step(1'b0);
            ioctl_wr = 1'b0;
            if (acc_now) begin
                ref_ram[dl_a[b][1:0]] = dl_d[b];
                if (ref_cnt < DEPTH) ref_cnt++;
            end
            acc_now = 1'b0;
        end
        for (int k = 0; k < 20 && wait0; k++) step(1'b0);
        ioctl_download = 1'b0;
        step(1'b0);
        if (in_load) ref_ready = (ref_cnt == DEPTH);
        in_load = 1'b0;
        chk("ready0", 48'(ready0), 48'(ref_ready));
        chk("ready1", 48'(ready1), 48'(ref_ready));
    endtask

    task automatic rand_full();
        for (int i = 0; i < 4; i++) begin
            dl_a[i] = 25'(i);
            dl_d[i] = 8'($urandom);
        end
    endtask

    initial begin
        ovl_en = 1'b1;
        bg_rgb = 24'($urandom);
        fg_rgb = 24'($urandom);
        // Reset state
        for (int i = 0; i < 5; i++) step(1'b1);
        chk("rst_ready0", 48'(ready0), 48'(0));
        chk("rst_ready1", 48'(ready1), 48'(0));
        reset_n = 1'b1;
        frame();                              // nothing loaded: background only

        // Directed full download, with one back-to-back write
        dl_a[0] = 25'd0; dl_d[0] = 8'h80;
        dl_a[1] = 25'd1; dl_d[1] = 8'h01;
        dl_a[2] = 25'd2; dl_d[2] = 8'hFF;
        dl_a[3] = 25'd3; dl_d[3] = 8'h00;
        download(8'd1, 4, 1'b1);
        ovl_x = 12'd2; ovl_y = 12'd1; fg_rgb = 24'hFF0000; bg_rgb = 24'h0000FF;
        settle(); frame();
        fg_rgb = 24'hFF8000; bg_rgb = 24'h0080FF;
        settle(); frame();

        // Short download: 3 bytes
        rand_full();
        download(8'd1, 3, 1'b0);
        settle(); frame();
        // Four writes, one past the end
        rand_full(); dl_a[2] = 25'd4;
        download(8'd1, 4, 1'b0);
        settle(); frame();

        // Random full loads and placements, including clipped windows
        for (int t = 0; t < 3; t++) begin
            rand_full();
            download(8'd1, 4, 1'b0);
            ovl_x  = 12'($urandom_range(0, 20));
            ovl_y  = 12'($urandom_range(0, 10));
            fg_rgb = 24'($urandom);
            bg_rgb = 24'($urandom);
            settle(); frame();
        end

        // Wrong index: ignored, RAM and ready unchanged
        rand_full();
        download(8'd2, 4, 1'b0);
        ovl_x = 12'd0; ovl_y = 12'd0;
        settle(); frame();
        ovl_en = 1'b0;
        settle(); frame();
        ovl_en = 1'b1;

        // Reset in the middle of a load
        ioctl_index = 8'd1; ioctl_download = 1'b1;
        step(1'b0);
        in_load = 1'b1;
        ioctl_addr = 25'd0; ioctl_dout = 8'h5A; ioctl_wr = 1'b1; acc_now = 1'b1;
        step(1'b0);
        ioctl_wr = 1'b0; acc_now = 1'b0; ref_ram[0] = 8'h5A;
        step(1'b0);
        reset_n = 1'b0;
        step(1'b1); step(1'b1);
        in_load = 1'b0; ref_ready = 1'b0;
        chk("midload_ready0", 48'(ready0), 48'(0));
        chk("midload_ready1", 48'(ready1), 48'(0));
        ioctl_download = 1'b0;
        reset_n = 1'b1;
        frame();
        rand_full();
        download(8'd1, 4, 1'b0);
        ovl_x = 12'd5; ovl_y = 12'd3;
        settle(); frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
